dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Responder side of the data-memory interface driven by the memory stage.
- Accepts one load/store request at a time over a valid/ready handshake.
- Applies a configurable number of wait states, then performs byte/halfword/word access on an internal word array with RV32I sub-word semantics.
- Returns read data with a one-cycle response strobe; a multi-cycle data_memory replacement so the pipeline can stall on memory.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two)
WAIT_STATES, 1, extra cycles between accept and access (0..15)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
req_valid  in  1  request present
req_ready  out  1  responder can accept
req_write  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I load/store funct3
req_addr  in  32  byte address
req_wdata  in  32  store data (right-aligned)
rsp_valid  out  1  one-cycle response strobe
rsp_rdata  out  32  load result, extended
rsp_error  out  1  access rejected

Behaviour:
- Reset (rst=0 at edge): state IDLE, wait counter 0, rsp_valid=0, rsp_rdata=0, rsp_error=0; req_ready=1 from the first cycle after reset. Array contents are not reset.
- FSM states and transitions:
  - IDLE: req_ready=1. req_valid&&req_ready at edge E0 latches write, funct3, addr, wdata. Next state is WAIT if WAIT_STATES>0, else ACCESS.
  - WAIT: counter loads WAIT_STATES-1 on entry and decrements each cycle; at 0 the next state is ACCESS. req_ready=0.
  - ACCESS: one cycle. At its closing edge the array is written (stores) or read into the response register (loads); next state RESP.
  - RESP: rsp_valid=1, rsp_rdata/rsp_error valid for exactly one cycle; next state IDLE.
- Timing: rsp_valid is high in the cycle following edge E0+WAIT_STATES+1. The earliest next accept is edge E0+WAIT_STATES+3.
- No response backpressure: the consumer must sample in the RESP cycle.
- rsp_rdata=0 and rsp_error=0 whenever rsp_valid=0.
- Addressing: word index = req_addr[log2(DEPTH_WORDS)+1:2]. Higher address bits are ignored (aliasing wrap).
- Stores: SB writes lane addr[1:0] with wdata[7:0]. SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0]. SW writes all 4 lanes. Unwritten lanes are preserved.
- Loads: the word is read and the selected lane(s) extracted. LB/LH sign-extend; LBU/LHU zero-extend; LW is the full word.
- For stores, rsp_valid still pulses and rsp_rdata=0.
- Reserved funct3 (loads 011/110/111, stores 011..111): no array write, rsp_rdata=0, rsp_error=1, same timing.
- Misaligned access, macro absent: low address bits beyond the access size are ignored (halfword uses addr[1], word uses none); rsp_error=0.
- req_valid while not in IDLE is ignored (req_ready=0); the requester must hold the request until accepted.
- Reset mid-operation: rst has priority. A pending transaction is dropped with no array write even if in ACCESS, and no response pulse.

Optional Feature:
- Macro DMEM_MISALIGN_TRAP_EN.
- Defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, is rejected: no array write, rsp_rdata=0, rsp_error=1, normal timing.
- Undefined: the misaligned rule above applies (silent alignment, rsp_error=0).

Decomposition:
- common_pkg:
  - mem_funct3_e (LB=000, LH=001, LW=010, LBU=100, LHU=101; SB/SH/SW reuse 000/001/010)
  - dmem_state_e (IDLE, WAIT, ACCESS, RESP)
  - DMEM_MAX_WAIT=15
- Sub-module dmem_lane_align (combinational):
  - from funct3, addr[1:0], wdata → 4-bit byte enable, lane-shifted store data, reserved/misaligned flags
  - from funct3, addr[1:0], raw word → extended load data

Test Plan:
- Reset with rst=0 for 3 cycles, then release → req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_error=0; no array write.
- WAIT_STATES=1: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 → rsp_valid exactly 2 cycles after each accept edge; load returns 0xDEADBEEF.
- After the above: SB 0x11 data 0x7F; LB 0x13 → 0xFFFFFFDE; LBU 0x13 → 0x000000DE; LH 0x10 → 0x00007FEF; LW 0x10 → 0xDEAD7FEF.
- Reserved funct3=011 store to 0x10 → rsp_error=1, rsp_rdata=0; a subsequent LW 0x10 still returns 0xDEAD7FEF.
- LW 0x12, macro undefined → 0xDEAD7FEF, rsp_error=0. Macro defined → rsp_error=1, rsp_rdata=0; SH 0x11 writes nothing.
- Reset asserted during WAIT of an SW 0x20 data 0x12345678 → no rsp_valid; a subsequent LW 0x20 returns the prior contents. Also: req_valid held during WAIT/RESP is not accepted until IDLE, and address 0x1010 aliases 0x10 with DEPTH_WORDS=1024.

Source files
------------

// File: rtl/common_pkg.sv
// Shared types for the data-memory responder: funct3 encodings, FSM states, wait limits.
package common_pkg;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } mem_funct3_e;

  // Store encodings share the load codes for the same access size.
  localparam logic [2:0] SB = 3'b000;
  localparam logic [2:0] SH = 3'b001;
  localparam logic [2:0] SW = 3'b010;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } dmem_state_e;

  localparam int DMEM_MAX_WAIT = 15;
  localparam int DMEM_CNT_W    = $clog2(DMEM_MAX_WAIT + 1);

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational RV32I lane steering: store byte enables / lane data and load extraction.
module dmem_lane_align
  import common_pkg::*;
(
  input  logic        is_write,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_raw,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lane,
  output logic        reserved,
  output logic        misaligned,
  output logic [31:0] rdata_ext
);

  mem_funct3_e f3;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  assign f3        = mem_funct3_e'(funct3);
  assign lane_byte = rdata_raw[{addr_lo, 3'b000} +: 8];
  assign lane_half = addr_lo[1] ? rdata_raw[31:16] : rdata_raw[15:0];

  always_comb begin
    byte_en    = 4'b0000;
    wdata_lane = 32'h0;
    reserved   = 1'b0;
    misaligned = 1'b0;
    rdata_ext  = 32'h0;
    case (f3)
      LB: begin
        byte_en    = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = {{24{lane_byte[7]}}, lane_byte};
      end
      LH: begin
        byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = {{16{lane_half[15]}}, lane_half};
        misaligned = addr_lo[0];
      end
      LW: begin
        byte_en    = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = rdata_raw;
        misaligned = |addr_lo;
      end
      LBU: begin
        reserved  = is_write;
        rdata_ext = {24'h0, lane_byte};
      end
      LHU: begin
        reserved   = is_write;
        rdata_ext  = {16'h0, lane_half};
        misaligned = addr_lo[0];
      end
      default: reserved = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder with wait states and RV32I sub-word access.
// Optional macro DMEM_MISALIGN_TRAP_EN rejects misaligned halfword/word accesses.
module dmem_responder
  import common_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [DMEM_CNT_W-1:0] WAIT_LOAD =
    DMEM_CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  dmem_state_e           state_q, state_d;
  logic [DMEM_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                  write_q, write_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [IDX_W+1:0]      addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_error_q, rsp_error_d;

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] mem_rdata;
  logic        accept;
  logic        mem_we;
  logic        reject;
  logic [3:0]  byte_en;
  logic [31:0] wdata_lane;
  logic [31:0] rdata_ext;
  logic        reserved;
  logic        misaligned;
  logic        unused_addr_hi;

  // Upper address bits alias onto the array and are deliberately dropped.
  assign unused_addr_hi = ^req_addr[31:IDX_W+2];
  assign accept         = req_valid && req_ready;
  assign mem_rdata      = mem[addr_q[IDX_W+1:2]];

  dmem_lane_align u_align (
    .is_write   (write_q),
    .funct3     (funct3_q),
    .addr_lo    (addr_q[1:0]),
    .wdata      (wdata_q),
    .rdata_raw  (mem_rdata),
    .byte_en    (byte_en),
    .wdata_lane (wdata_lane),
    .reserved   (reserved),
    .misaligned (misaligned),
    .rdata_ext  (rdata_ext)
  );

`ifdef DMEM_MISALIGN_TRAP_EN
  assign reject = reserved | misaligned;
`else
  logic unused_misaligned;
  assign unused_misaligned = misaligned;
  assign reject            = reserved;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      write_q     <= 1'b0;
      funct3_q    <= 3'b000;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      rsp_rdata_q <= 32'h0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      write_q     <= write_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (WAIT_STATES > 0) begin
            state_d    = WAIT;
            wait_cnt_d = WAIT_LOAD;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      WAIT: begin
        if (wait_cnt_q == '0) begin
          state_d = ACCESS;
        end else begin
          wait_cnt_d = wait_cnt_q - DMEM_CNT_W'(1);
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Response registers are loaded only at the ACCESS edge, so they read zero outside RESP.
  always_comb begin
    write_d     = accept ? req_write : write_q;
    funct3_d    = accept ? req_funct3 : funct3_q;
    addr_d      = accept ? req_addr[IDX_W+1:0] : addr_q;
    wdata_d     = accept ? req_wdata : wdata_q;
    rsp_rdata_d = 32'h0;
    rsp_error_d = 1'b0;
    mem_we      = 1'b0;
    if (state_q == ACCESS) begin
      rsp_error_d = reject;
      mem_we      = write_q && !reject;
      if (!write_q && !reject) begin
        rsp_rdata_d = rdata_ext;
      end
    end
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    rsp_rdata = rsp_rdata_q;
    rsp_error = rsp_error_q;
  end

  // Array is not reset, but reset still suppresses a pending store.
  always_ff @(posedge clk) begin
    if (rst && mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem[addr_q[IDX_W+1:2]][8*b +: 8] <= wdata_lane[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder (WAIT_STATES=1, DEPTH_WORDS=1024).
module tb_dmem_responder;

  localparam int WS = 1;
  localparam int DEPTH = 1024;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] model_mem [DEPTH];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_error  (rsp_error)
  );

  always #5 clk = ~clk;

  // Reference: byte-addressed RV32I semantics on a word array, written from the rules.
  function automatic void model_access(input logic wr, input logic [2:0] f3,
                                       input logic [31:0] addr, input logic [31:0] wd,
                                       output logic [31:0] exp_rd, output logic exp_err);
    int idx, nb, off;
    logic [31:0] w, mask, val;
    logic rsv, mis;
    idx = int'(addr[11:2]);
    nb  = 1 << f3[1:0];
    off = (nb == 1) ? int'(addr[1:0]) : (nb == 2) ? (addr[1] ? 2 : 0) : 0;
    rsv = wr ? (f3 >= 3'd3) : (f3 == 3'd3 || f3 >= 3'd6);
    mis = (nb == 2 && addr[0]) || (nb == 4 && addr[1:0] != 2'b00);
    exp_rd  = 32'h0;
    exp_err = rsv || (TRAP && mis);
    if (exp_err) return;
    if (wr) begin
      for (int i = 0; i < nb; i++) model_mem[idx][8*(off+i) +: 8] = wd[8*i +: 8];
    end else begin
      w    = model_mem[idx];
      mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*nb)) - 32'd1);
      val  = (w >> (8*off)) & mask;
      if (!f3[2] && nb < 4 && val[8*nb-1]) val = val | ~mask;
      exp_rd = val;
    end
  endfunction

  // Drives one request from a negedge; returns at the negedge after the response cycle.
  task automatic run_txn(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output int lat, output logic [31:0] rd,
                         output logic err, output logic quiet_ok, output logic single_ok);
    int n;
    lat = -1; rd = 32'h0; err = 1'b0; quiet_ok = 1'b1; single_ok = 1'b1;
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (rsp_valid) begin
        lat = k; rd = rsp_rdata; err = rsp_error;
        break;
      end
      if (rsp_rdata !== 32'h0 || rsp_error !== 1'b0) quiet_ok = 1'b0;
      @(negedge clk);
    end
    if (lat < 0) return;
    @(negedge clk);
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_error !== 1'b0) single_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({req_ready, rsp_valid, rsp_error} !== 3'b100 || rsp_rdata !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got ready=%b valid=%b err=%b rdata=%h, want 1 0 0 00000000",
               req_ready, rsp_valid, rsp_error, rsp_rdata);
    end
  endtask

  task automatic test_word();
    int lat; logic [31:0] rd; logic err, q, s;
    run_txn(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, lat, rd, err, q, s);
    vectors++;
    if (lat !== WS + 2 || !q || !s || rd !== 32'h0 || err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL sw_0x10: got lat=%0d quiet=%b single=%b rdata=%h err=%b, want lat=%0d 1 1 00000000 0",
               lat, q, s, rd, err, WS + 2);
    end
    run_txn(1'b0, 3'b010, 32'h10, 32'h0, lat, rd, err, q, s);
    vectors++;
    if (lat !== WS + 2 || !q || !s || rd !== 32'hDEAD_BEEF || err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL lw_0x10: got lat=%0d quiet=%b single=%b rdata=%h err=%b, want lat=%0d 1 1 deadbeef 0",
               lat, q, s, rd, err, WS + 2);
    end
  endtask

  task automatic test_subword();
    int lat; logic [31:0] rd; logic err, q, s;
    logic [2:0]  f3s  [6] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b010, 3'b101};
    logic [31:0] adrs [6] = '{32'h11, 32'h13, 32'h13, 32'h10, 32'h10, 32'h12};
    logic [31:0] exps [6] = '{32'h0, 32'hFFFF_FFDE, 32'h0000_00DE, 32'h0000_7FEF,
                              32'hDEAD_7FEF, 32'h0000_DEAD};
    for (int i = 0; i < 6; i++) begin
      run_txn(i == 0, f3s[i], adrs[i], 32'hAAAA_AA7F, lat, rd, err, q, s);
      vectors++;
      if (lat !== WS + 2 || !q || !s || rd !== exps[i] || err !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL subword_%0d: got lat=%0d quiet=%b single=%b rdata=%h err=%b, want rdata=%h err=0",
                 i, lat, q, s, rd, err, exps[i]);
      end
    end
  endtask

  task automatic test_reserved();
    int lat; logic [31:0] rd; logic err, q, s;
    run_txn(1'b1, 3'b011, 32'h10, 32'hFFFF_FFFF, lat, rd, err, q, s);
    vectors++;
    if (lat !== WS + 2 || rd !== 32'h0 || err !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rsv_store: got lat=%0d rdata=%h err=%b, want lat=%0d 00000000 1", lat, rd, err, WS + 2);
    end
    run_txn(1'b0, 3'b110, 32'h10, 32'h0, lat, rd, err, q, s);
    vectors++;
    if (lat !== WS + 2 || rd !== 32'h0 || err !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rsv_load: got lat=%0d rdata=%h err=%b, want lat=%0d 00000000 1", lat, rd, err, WS + 2);
    end
    run_txn(1'b0, 3'b010, 32'h10, 32'h0, lat, rd, err, q, s);
    vectors++;
    if (rd !== 32'hDEAD_7FEF || err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rsv_nowrite: got rdata=%h err=%b, want deadbeef-patched dead7fef 0", rd, err);
    end
  endtask

  task automatic test_misaligned();
    int lat; logic [31:0] rd; logic err, q, s;
    logic [31:0] exp_lw, exp_word;
    logic exp_e;
    exp_lw   = TRAP ? 32'h0 : 32'hDEAD_7FEF;
    exp_e    = TRAP;
    exp_word = TRAP ? 32'h1122_3344 : 32'h1122_AAAA;
    run_txn(1'b0, 3'b010, 32'h12, 32'h0, lat, rd, err, q, s);
    vectors++;
    if (lat !== WS + 2 || rd !== exp_lw || err !== exp_e) begin
      miscompares++;
      $display("[TB] FAIL mis_lw: got lat=%0d rdata=%h err=%b, want %h %b", lat, rd, err, exp_lw, exp_e);
    end
    run_txn(1'b1, 3'b010, 32'h30, 32'h1122_3344, lat, rd, err, q, s);
    run_txn(1'b1, 3'b001, 32'h31, 32'h5555_AAAA, lat, rd, err, q, s);
    vectors++;
    if (rd !== 32'h0 || err !== exp_e) begin
      miscompares++;
      $display("[TB] FAIL mis_sh: got rdata=%h err=%b, want 00000000 %b", rd, err, exp_e);
    end
    run_txn(1'b0, 3'b010, 32'h30, 32'h0, lat, rd, err, q, s);
    vectors++;
    if (rd !== exp_word || err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL mis_sh_effect: got rdata=%h err=%b, want %h 0", rd, err, exp_word);
    end
  endtask

  task automatic test_reset_midop();
    int lat; logic [31:0] rd; logic err, q, s;
    logic seen;
    run_txn(1'b1, 3'b010, 32'h20, 32'hCAFE_F00D, lat, rd, err, q, s);
    for (int phase = 1; phase <= 2; phase++) begin
      req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
      req_addr = 32'h20; req_wdata = 32'h1234_5678;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      if (phase == 2) @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      repeat (2) begin
        @(negedge clk);
        if (rsp_valid !== 1'b0) seen = 1'b1;
      end
      rst = 1'b1;
      @(negedge clk);
      if (rsp_valid !== 1'b0) seen = 1'b1;
      vectors++;
      if (seen || req_ready !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL rst_midop_%0d: got rsp_seen=%b ready=%b, want 0 1", phase, seen, req_ready);
      end
      run_txn(1'b0, 3'b010, 32'h20, 32'h0, lat, rd, err, q, s);
      vectors++;
      if (rd !== 32'hCAFE_F00D || err !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL rst_nowrite_%0d: got rdata=%h err=%b, want cafef00d 0", phase, rd, err);
      end
    end
  endtask

  task automatic test_back_to_back();
    int first_ready, rsp1, rsp2;
    logic [31:0] rd2;
    first_ready = -1; rsp1 = -1; rsp2 = -1; rd2 = 32'h0;
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h1010; req_wdata = 32'hA5A5_0F0F;
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_write = 1'b0; req_addr = 32'h10; req_wdata = 32'h0;
      end
      if (first_ready >= 0 && k == first_ready + 1) req_valid = 1'b0;
      if (first_ready < 0 && req_ready) first_ready = k;
      if (rsp_valid) begin
        if (rsp1 < 0) rsp1 = k;
        else if (rsp2 < 0) begin
          rsp2 = k; rd2 = rsp_rdata;
        end
      end
    end
    req_valid = 1'b0;
    vectors++;
    if (first_ready !== WS + 3 || rsp1 !== WS + 2) begin
      miscompares++;
      $display("[TB] FAIL hold_accept: got ready_at=%0d rsp_at=%0d, want %0d %0d",
               first_ready, rsp1, WS + 3, WS + 2);
    end
    vectors++;
    if (rsp2 !== 2 * WS + 5 || rd2 !== 32'hA5A5_0F0F) begin
      miscompares++;
      $display("[TB] FAIL alias_0x1010: got rsp_at=%0d rdata=%h, want %0d a5a50f0f", rsp2, rd2, 2 * WS + 5);
    end
  endtask

  task automatic test_random();
    int lat; logic [31:0] rd, exp_rd, addr, wd; logic err, exp_err, q, s, wr;
    logic [2:0] f3;
    for (int i = 0; i < 8; i++) begin
      addr = {$urandom_range(0, 1023) << 12} | 32'h100 | (i << 2);
      wd   = $urandom;
      model_access(1'b1, 3'b010, addr, wd, exp_rd, exp_err);
      run_txn(1'b1, 3'b010, addr, wd, lat, rd, err, q, s);
    end
    for (int i = 0; i < 80; i++) begin
      wr   = $urandom_range(0, 1) == 1;
      f3   = 3'($urandom_range(0, 7));
      addr = {$urandom_range(0, 1023) << 12} | 32'h100 | ($urandom_range(0, 7) << 2)
             | $urandom_range(0, 3);
      wd   = $urandom;
      model_access(wr, f3, addr, wd, exp_rd, exp_err);
      run_txn(wr, f3, addr, wd, lat, rd, err, q, s);
      vectors++;
      if (lat !== WS + 2 || !q || !s || rd !== exp_rd || err !== exp_err) begin
        miscompares++;
        $display("[TB] FAIL rand_%0d wr=%b f3=%0d addr=%h: got lat=%0d quiet=%b single=%b rdata=%h err=%b, want lat=%0d rdata=%h err=%b",
                 i, wr, f3, addr, lat, q, s, rd, err, WS + 2, exp_rd, exp_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_subword();
    test_reserved();
    test_misaligned();
    test_reset_midop();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
